// File: rtl/intra_pkg.sv
// Shared definitions for the intra mode-decision cost path: geometry
// constants, FSM state encoding and pixel/sum types used by both the
// SAD accumulator and the downstream decision stage.
package intra_pkg;

    // Pixel geometry and accumulator sizing.
    localparam int PIX_W    = 8;
    localparam int LANES    = 4;
    localparam int SUM_W    = 12;
    localparam int MB_BEATS = 64;

    // Width of one beat's SAD: LANES differences of PIX_W bits each.
    localparam int DIFF_W   = PIX_W + $clog2(LANES);

    // Beat counter covers 0..MB_BEATS-1.
    localparam int CNT_W    = (MB_BEATS > 1) ? $clog2(MB_BEATS) : 1;

    // Macroblock accumulation phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } intra_sad_state_t;

    typedef logic [PIX_W-1:0]       pix_t;
    typedef logic [LANES*PIX_W-1:0] beat_t;
    typedef logic [DIFF_W-1:0]      diff_t;
    typedef logic [SUM_W-1:0]       sum_t;
    typedef logic [CNT_W-1:0]       cnt_t;

    // Unsigned absolute difference of two pixels.
    function automatic pix_t abs_diff(input pix_t a, input pix_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Accumulate one beat's SAD, clamping at the all-ones sum instead of wrapping.
    function automatic sum_t sat_add(input sum_t acc, input diff_t d);
        logic [SUM_W:0] wide;
        wide = {1'b0, acc} + (SUM_W + 1)'(d);
        return wide[SUM_W] ? {SUM_W{1'b1}} : wide[SUM_W-1:0];
    endfunction

endpackage : intra_pkg

// File: rtl/intra_sad4.sv
// Combinational LANES-wide absolute-difference adder: the SAD of one beat of
// original pixels against one candidate prediction. Lane 0 sits in the LSBs.
module intra_sad4
    import intra_pkg::*;
(
    input  logic [LANES*PIX_W-1:0] i_orig,
    input  logic [LANES*PIX_W-1:0] i_pred,
    output logic [DIFF_W-1:0]      o_sad
);

    diff_t w_sad;

    // Sum the per-lane absolute differences; written as a chain, synthesis
    // rebalances it into a tree.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch or
        // loop, so no path can leave it unassigned and infer a latch.
        w_sad = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sad = w_sad + DIFF_W'(abs_diff(i_orig[i*PIX_W +: PIX_W],
                                             i_pred[i*PIX_W +: PIX_W]));
        end
    end

    assign o_sad = w_sad;

endmodule : intra_sad4

// File: rtl/intra_sad_accum.sv
// Intra cost stage: streams one 16x16 macroblock (MB_BEATS beats of LANES
// pixels) together with the 4x4 and 16x16 candidate predictions and
// accumulates a saturating SAD for each. A one-cycle EMIT bubble after the
// final beat publishes both sums with a single sum_valid pulse; the sums then
// hold until the next macroblock is emitted.
module intra_sad_accum
    import intra_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [LANES*PIX_W-1:0] orig_px,
    input  logic [LANES*PIX_W-1:0] pred4_px,
    input  logic [LANES*PIX_W-1:0] pred16_px,
    output logic [SUM_W-1:0]       sum_4x4,
    output logic [SUM_W-1:0]       sum_16x16,
    output logic                   sum_valid,
    output logic                   len_err
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    intra_sad_state_t r_state;
    intra_sad_state_t w_next_state;

    cnt_t  r_beat_cnt;
    sum_t  r_acc4;
    sum_t  r_acc16;
    sum_t  r_sum4;
    sum_t  r_sum16;
    logic  r_sum_valid;
    logic  r_len_err;
    logic  r_in_ready;

    diff_t w_d4;
    diff_t w_d16;
    logic  w_accept;
    logic  w_cnt_last;
    logic  w_first;

    // ------------------------------------------------------------------
    // Per-beat SADs for both candidate modes
    // ------------------------------------------------------------------
    intra_sad4 u_sad_4x4 (
        .i_orig (orig_px),
        .i_pred (pred4_px),
        .o_sad  (w_d4)
    );

    intra_sad4 u_sad_16x16 (
        .i_orig (orig_px),
        .i_pred (pred16_px),
        .o_sad  (w_d16)
    );

    // A beat moves only on a valid/ready handshake; everything else on the
    // input bus is ignored, including whatever it carries while in_valid=0.
    assign w_accept   = in_valid & r_in_ready;

    // Macroblock end is decided purely by the count, never by in_last.
    assign w_cnt_last = (r_beat_cnt == CNT_W'(MB_BEATS - 1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: state elements are assigned with <= so every flop samples
            // the pre-edge values, independent of block ordering.
            r_state <= w_next_state;
        end
    end

    // Next-state decode; w_first marks the beat that opens a macroblock.
    always_comb begin
        w_next_state = r_state;
        w_first      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_first      = 1'b1;
                    w_next_state = w_cnt_last ? EMIT : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept && w_cnt_last) begin
                    w_next_state = EMIT;
                end
            end
            EMIT: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // in_ready is registered from the next state: low through reset and the
    // first edge after it, low for the EMIT cycle, high otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state != EMIT);
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Beat counter: advances per accepted beat, cleared in EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (r_state == EMIT) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= w_cnt_last ? '0 : r_beat_cnt + 1'b1;
        end
    end

    // Saturating accumulators; the opening beat loads rather than adds so no
    // residue of the previous macroblock survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc4  <= '0;
            r_acc16 <= '0;
        end else if (w_accept) begin
            r_acc4  <= w_first ? SUM_W'(w_d4)  : sat_add(r_acc4,  w_d4);
            r_acc16 <= w_first ? SUM_W'(w_d16) : sat_add(r_acc16, w_d16);
        end
    end

    // Publish both sums in EMIT with a one-cycle valid pulse; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum4      <= '0;
            r_sum16     <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= (r_state == EMIT);
            if (r_state == EMIT) begin
                r_sum4  <= r_acc4;
                r_sum16 <= r_acc16;
            end
        end
    end

    // Sticky framing error: producer's in_last disagrees with the beat count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_err <= 1'b0;
        end else if (w_accept && (in_last != w_cnt_last)) begin
            r_len_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = r_in_ready;
    assign sum_4x4   = r_sum4;
    assign sum_16x16 = r_sum16;
    assign sum_valid = r_sum_valid;
    assign len_err   = r_len_err;

endmodule : intra_sad_accum

// File: tb/tb_intra_sad_accum.sv
// Directed testbench for intra_sad_accum: hand-computed SAD totals for flat,
// lane-varying, saturating, back-to-back, misframed and reset-interrupted
// macroblocks, plus cycle-exact checks of in_ready and sum_valid timing.
module tb_intra_sad_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [31:0] orig_px;
    logic [31:0] pred4_px;
    logic [31:0] pred16_px;
    logic [11:0] sum_4x4;
    logic [11:0] sum_16x16;
    logic        sum_valid;
    logic        len_err;

    intra_sad_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .orig_px   (orig_px),
        .pred4_px  (pred4_px),
        .pred16_px (pred16_px),
        .sum_4x4   (sum_4x4),
        .sum_16x16 (sum_16x16),
        .sum_valid (sum_valid),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Count one comparison and report it if the observed value is off.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge: cycle count, sum_valid pulses and in_ready-low cycles.
    int          cyc     = 0;
    int          sv_cnt  = 0;
    int          rdy_low = 0;
    int          sv_cyc[$];
    logic [11:0] sv_s4[$];
    logic [11:0] sv_s16[$];

    always @(negedge clk) begin
        cyc++;
        if (sum_valid === 1'b1) begin
            sv_cnt++;
            sv_cyc.push_back(cyc);
            sv_s4.push_back(sum_4x4);
            sv_s16.push_back(sum_16x16);
        end
        if (rst_n === 1'b1 && in_ready !== 1'b1) rdy_low++;
    end

    function automatic logic [31:0] rep(input logic [7:0] p);
        return {4{p}};
    endfunction

    // Present one beat and hold it until the handshake completes (bounded).
    task automatic drive_beat(input logic [31:0] o, input logic [31:0] p4,
                              input logic [31:0] p16, input logic last);
        int waits;
        waits     = 0;
        in_valid  = 1'b1;
        orig_px   = o;
        pred4_px  = p4;
        pred16_px = p16;
        in_last   = last;
        while (in_ready !== 1'b1 && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (in_ready !== 1'b1) check("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    // One cycle with no beat offered and garbage on the data/last lines.
    task automatic idle_cycle();
        in_valid  = 1'b0;
        in_last   = 1'($urandom);
        orig_px   = $urandom;
        pred4_px  = $urandom;
        pred16_px = $urandom;
        @(posedge clk); #1;
    endtask

    // A full macroblock of identical beats, in_last on beat last_at, with an
    // idle cycle after every gap_every-th beat when gap_every > 0.
    task automatic run_mb(input logic [31:0] o, input logic [31:0] p4,
                          input logic [31:0] p16, input int last_at, input int gap_every);
        for (int b = 0; b < 64; b++) begin
            drive_beat(o, p4, p16, (b == last_at));
            if (gap_every > 0 && b != 63 && (b % gap_every) == gap_every - 1) idle_cycle();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called just after the final beat's edge: EMIT now, sums one edge later.
    task automatic expect_emit(input string tag, input logic [31:0] e4, input logic [31:0] e16);
        check({tag, "_ready_in_emit"}, 32'(in_ready), 32'd0);
        check({tag, "_valid_early"},   32'(sum_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid_pulse"},   32'(sum_valid), 32'd1);
        check({tag, "_sum_4x4"},       32'(sum_4x4), e4);
        check({tag, "_sum_16x16"},     32'(sum_16x16), e16);
        check({tag, "_ready_back"},    32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check({tag, "_valid_drop"},    32'(sum_valid), 32'd0);
        check({tag, "_sum_4x4_hold"},  32'(sum_4x4), e4);
        check({tag, "_sum_16x16_hold"}, 32'(sum_16x16), e16);
    endtask

    // Safety net in case the DUT wedges somewhere the bounded waits miss.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        int r0;
        int p0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        orig_px   = '0;
        pred4_px  = '0;
        pred16_px = '0;

        // Reset held with random traffic: every output must stay at zero.
        repeat (4) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom);
            in_last   = 1'($urandom);
            orig_px   = $urandom;
            pred4_px  = $urandom;
            pred16_px = $urandom;
        end
        check("rst_sum_4x4",   32'(sum_4x4), 32'd0);
        check("rst_sum_16x16", 32'(sum_16x16), 32'd0);
        check("rst_sum_valid", 32'(sum_valid), 32'd0);
        check("rst_len_err",   32'(len_err), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd0);

        @(posedge clk); #3;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("ready_before_first_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_first_edge",  32'(in_ready), 32'd1);

        // Flat MB: d4 = 0, d16 = 4*2 per beat -> 512.
        run_mb(rep(8'd100), rep(8'd100), rep(8'd98), 63, 0);
        expect_emit("flat", 32'd0, 32'd512);
        check("flat_len_err", 32'(len_err), 32'd0);

        // Lane-varying MB with idle gaps. Lanes 0..3: orig 10,20,30,40;
        // pred4 12,17,30,45 -> 2+3+0+5 = 10/beat -> 640;
        // pred16 11,20,33,37 -> 1+0+3+3 = 7/beat -> 448.
        run_mb({8'd40, 8'd30, 8'd20, 8'd10}, {8'd45, 8'd30, 8'd17, 8'd12},
               {8'd37, 8'd33, 8'd20, 8'd11}, 63, 5);
        expect_emit("lanes", 32'd640, 32'd448);

        // Saturation: 1020/beat and 1016/beat both exceed 4095 quickly.
        run_mb(rep(8'd255), rep(8'd0), rep(8'd1), 63, 0);
        expect_emit("sat", 32'd4095, 32'd4095);

        // Back-to-back at full rate: MB1 d4=1/px (256), d16=0; MB2 d4=2/px (512), d16=3/px (768).
        k0 = sv_cnt;
        r0 = rdy_low;
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < 64; b++) begin
                drive_beat(rep(8'd50), (m == 0) ? rep(8'd51) : rep(8'd48),
                           (m == 0) ? rep(8'd50) : rep(8'd53), (b == 63));
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_pulse_count", 32'(sv_cnt - k0), 32'd2);
        if (sv_cnt >= k0 + 2) begin
            check("b2b_mb1_sum_4x4",   32'(sv_s4[k0]),      32'd256);
            check("b2b_mb1_sum_16x16", 32'(sv_s16[k0]),     32'd0);
            check("b2b_mb2_sum_4x4",   32'(sv_s4[k0+1]),    32'd512);
            check("b2b_mb2_sum_16x16", 32'(sv_s16[k0+1]),   32'd768);
            check("b2b_pulse_spacing", 32'(sv_cyc[k0+1] - sv_cyc[k0]), 32'd65);
        end
        check("b2b_ready_low_cycles", 32'(rdy_low - r0), 32'd2);

        // Early in_last on beat 10: sticky len_err, accumulation still by count.
        for (int b = 0; b < 64; b++) begin
            drive_beat(rep(8'd7), rep(8'd5), rep(8'd7), (b == 10));
            if (b == 9)  check("lenerr_before_beat10", 32'(len_err), 32'd0);
            if (b == 10) check("lenerr_at_beat10",     32'(len_err), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_emit("lenerr", 32'd512, 32'd0);
        check("lenerr_sticky", 32'(len_err), 32'd1);

        // Asynchronous reset clears sums and the sticky flag immediately.
        rst_n = 1'b0;
        #1;
        check("arst_sum_4x4", 32'(sum_4x4), 32'd0);
        check("arst_len_err", 32'(len_err), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-macroblock at beat 30, then a clean MB with d16=3/px -> 768.
        p0 = sv_cnt;
        for (int b = 0; b < 30; b++) begin
            drive_beat(rep(8'd20), rep(8'd90), rep(8'd0), 1'b0);
        end
        rst_n = 1'b0;
        #2;
        check("midrst_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_mb(rep(8'd20), rep(8'd20), rep(8'd23), 63, 0);
        expect_emit("midrst", 32'd0, 32'd768);
        check("midrst_single_pulse", 32'(sv_cnt - p0), 32'd1);
        check("midrst_len_err",      32'(len_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_intra_sad_accum
